// File: rtl/xadc_multi_sampler.sv
// Multi-channel XADC sampler: sweeps the enabled aux channels over the DRP, averages
// 2^AVG_LOG2 conversions per channel and flags averages above a programmable threshold.
module xadc_multi_sampler #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned ADC_BITS = 12,
  parameter int unsigned AVG_LOG2 = 2,
  parameter logic [6:0]  BASE_CH  = 7'h12,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  input  logic              bus_we,
  output logic [31:0]       bus_rdata,
  output logic              den_out,
  output logic [6:0]        daddr_out,
  input  logic              drdy_in,
  input  logic [15:0]       do_in,
  input  logic              eoc_in,
  output logic              irq
);

  localparam int unsigned SumW = ADC_BITS + AVG_LOG2;
  localparam int unsigned ChW  = $clog2(NUM_CH + 1);
  localparam int unsigned CntW = AVG_LOG2 + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StScan, StWaitEoc, StReq, StWaitRdy, StAcc, StStore, StFinish
  } state_e;

  state_e                          state_q, state_d;
  logic                            cont_q, cont_d;
  logic [7:0]                      thr_q, thr_d, thr_w_q, thr_w_d;
  logic [NUM_CH-1:0]               mask_q, mask_d, mask_w_q, mask_w_d;
  logic                            done_q, done_d, err_q, err_d;
  logic [NUM_CH-1:0]               flag_q, flag_d;
  logic [NUM_CH-1:0][ADC_BITS-1:0] data_q, data_d;
  logic [ChW-1:0]                  ch_q, ch_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [SumW-1:0]                 sum_q, sum_d;
  logic [TmoW-1:0]                 tmo_q, tmo_d;
  logic [ADC_BITS-1:0]             sample_q, sample_d;
  logic                            den_q, den_d;
  logic [6:0]                      daddr_q, daddr_d;

  logic                            ctrl_wr, start_req, clr_req, tmo_hit;
  logic                            scan_hit;
  logic [ChW-1:0]                  scan_ch;
  logic [ADC_BITS-1:0]             avg;
  logic                            unused_bits;

  assign ctrl_wr     = bus_we && (bus_addr == '0);
  assign start_req   = ctrl_wr && bus_wdata[0];
  assign clr_req     = ctrl_wr && bus_wdata[2];
  assign tmo_hit     = (tmo_q == TmoW'(TIMEOUT - 1));
  assign unused_bits = ^{bus_wdata, do_in};

  always_comb begin
    state_d  = state_q;
    cont_d   = cont_q;
    thr_d    = thr_q;
    mask_d   = mask_q;
    thr_w_d  = thr_w_q;
    mask_w_d = mask_w_q;
    done_d   = done_q;
    err_d    = err_q;
    flag_d   = flag_q;
    data_d   = data_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    tmo_d    = tmo_q;
    sample_d = sample_q;
    den_d    = 1'b0;
    daddr_d  = daddr_q;
    avg      = ADC_BITS'(sum_q >> AVG_LOG2);

    // Lowest enabled channel at or above ch_q, resolved in a single cycle.
    scan_hit = 1'b0;
    scan_ch  = ch_q;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!scan_hit && mask_w_q[i] && (ChW'(i) >= ch_q)) begin
        scan_hit = 1'b1;
        scan_ch  = ChW'(i);
      end
    end

    if (ctrl_wr) begin
      cont_d = bus_wdata[1];
      thr_d  = bus_wdata[15:8];
      mask_d = bus_wdata[16 +: NUM_CH];
    end
    // Clear first so that a set event later in this block takes priority.
    if (clr_req) begin
      done_d = 1'b0;
      err_d  = 1'b0;
      flag_d = '0;
    end

    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          done_d   = 1'b0;
          err_d    = 1'b0;
          ch_d     = '0;
          thr_w_d  = thr_d;
          mask_w_d = mask_d;
          state_d  = StScan;
        end
      end
      StScan: begin
        if (scan_hit) begin
          ch_d    = scan_ch;
          tmo_d   = '0;
          state_d = StWaitEoc;
        end else begin
          state_d = StFinish;
        end
      end
      StWaitEoc: begin
        if (eoc_in) begin
          den_d   = 1'b1;
          daddr_d = BASE_CH + 7'(ch_q);
          state_d = StReq;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StReq: begin
        tmo_d   = '0;
        state_d = StWaitRdy;
      end
      StWaitRdy: begin
        if (drdy_in) begin
          sample_d = do_in[15 -: ADC_BITS];
          state_d  = StAcc;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StAcc: begin
        sum_d = sum_q + SumW'(sample_q);
        if (cnt_q == CntW'((1 << AVG_LOG2) - 1)) begin
          state_d = StStore;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          tmo_d   = '0;
          state_d = StWaitEoc;
        end
      end
      StStore: begin
        for (int k = 0; k < int'(NUM_CH); k++) begin
          if (ChW'(k) == ch_q) begin
            data_d[k] = avg;
            if (avg[ADC_BITS-1 -: 8] > thr_w_q) flag_d[k] = 1'b1;
          end
        end
        sum_d   = '0;
        cnt_d   = '0;
        ch_d    = ch_q + 1'b1;
        state_d = StScan;
      end
      StFinish: begin
        done_d = 1'b1;
        if (cont_q) begin
          ch_d     = '0;
          thr_w_d  = thr_d;
          mask_w_d = mask_d;
          state_d  = StScan;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cont_q   <= 1'b0;
      thr_q    <= '0;
      mask_q   <= '0;
      thr_w_q  <= '0;
      mask_w_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      flag_q   <= '0;
      data_q   <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      tmo_q    <= '0;
      sample_q <= '0;
      den_q    <= 1'b0;
      daddr_q  <= BASE_CH;
    end else begin
      state_q  <= state_d;
      cont_q   <= cont_d;
      thr_q    <= thr_d;
      mask_q   <= mask_d;
      thr_w_q  <= thr_w_d;
      mask_w_q <= mask_w_d;
      done_q   <= done_d;
      err_q    <= err_d;
      flag_q   <= flag_d;
      data_q   <= data_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      tmo_q    <= tmo_d;
      sample_q <= sample_d;
      den_q    <= den_d;
      daddr_q  <= daddr_d;
    end
  end

  always_comb begin
    bus_rdata = '0;
    if (bus_addr == ADDR_W'(0)) begin
      bus_rdata[1]             = cont_q;
      bus_rdata[15:8]          = thr_q;
      bus_rdata[16 +: NUM_CH]  = mask_q;
    end else if (bus_addr == ADDR_W'(1)) begin
      bus_rdata[0]             = (state_q != StIdle);
      bus_rdata[1]             = done_q;
      bus_rdata[2]             = err_q;
      bus_rdata[8 +: NUM_CH]   = flag_q;
    end else begin
      for (int k = 0; k < int'(NUM_CH); k++) begin
        if (bus_addr == ADDR_W'(k + 2)) bus_rdata[ADC_BITS-1:0] = data_q[k];
      end
    end
  end

  assign den_out   = den_q;
  assign daddr_out = daddr_q;
  assign irq       = done_q | err_q;

endmodule
